// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin shared-line arbiter:
// state encoding, requester count, select width and reset owner.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Reset owner of 7 makes requester 0 the first in line after reset.
  localparam logic [SEL_W-1:0] RST_OWNER = 3'd7;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Scans req starting at
// ptr+1 and wrapping, so the requester at ptr has the lowest priority.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest priority slot to the highest so the last hit wins.
  always_comb begin
    found = |req;
    idx   = '0;
    cand  = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 8-way round-robin arbiter for a shared 8:1 data line.
// gnt/sel/busy are registered; y is the selected data bit, gated by busy.
// Optional hold limit: define ARB_TIMEOUT_EN to force a handoff after
// HOLD_MAX grant cycles while another requester is waiting.
//
//   state    | meaning
//   ST_IDLE  | no grant active, gnt=0, sel keeps last value
//   ST_GRANT | one requester owns the line, gnt one-hot, sel = owner
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               y
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("mux_rr_arbiter: HOLD_MAX must be within 2..255");
  end

  state_t               state, state_nx;
  logic [SEL_W-1:0]     last_owner, sel_nx;
  logic [NUM_REQ-1:0]   gnt_nx, pick_req;
  logic                 pick_found, take, force_switch;
  logic [SEL_W-1:0]     pick_idx;

  // While granted, the owner is excluded so a search always yields someone else.
  assign pick_req = (state == ST_GRANT) ? (req & ~gnt) : req;

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (last_owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       hold_expired;

  assign hold_expired = (hold_cnt == 8'(HOLD_MAX - 1));
  assign force_switch = hold_expired && pick_found;

  // Tenure counter: clears on every grant or return to idle, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst)                                hold_cnt <= '0;
    else if (take || state_nx == ST_IDLE)   hold_cnt <= '0;
    else if (!hold_expired)                 hold_cnt <= hold_cnt + 8'd1;
  end
`else
  assign force_switch = 1'b0;
`endif

  // State register plus registered outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      sel        <= '0;
      last_owner <= RST_OWNER;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      if (take) last_owner <= pick_idx;
    end
  end

  // Next state: grant from idle, hold, hand off, or fall back to idle.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nx = ST_GRANT;
          take     = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[sel] || force_switch) begin
          if (pick_found) take = 1'b1;
          else            state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode for the next cycle's grant vector and select.
  always_comb begin
    gnt_nx = gnt;
    sel_nx = sel;
    if (take) begin
      gnt_nx = onehot(pick_idx);
      sel_nx = pick_idx;
    end else if (state_nx == ST_IDLE) begin
      gnt_nx = '0;
    end
  end

  assign busy = (state == ST_GRANT);
  assign y    = busy & d[sel];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: a cycle-level reference model of the
// round-robin rules, a per-cycle compare process, and directed scenarios
// with literal expectations. Honours ARB_TIMEOUT_EN like the design.
module tb_mux_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] d   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .d    (d),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, last granted index, tenure length.
  bit m_valid = 1'b0;
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = 7;
  int m_sel   = 0;
  int m_ten   = 0;

  always @(posedge clk) begin
    bit switch_now;
    int win;
    int c;
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = 7;
      m_sel   = 0;
      m_ten   = 0;
    end else if (m_valid) begin
      win = -1;
      switch_now = !m_busy || !req[m_owner];
`ifdef ARB_TIMEOUT_EN
      if (m_busy && m_ten >= HOLD && (req & ~(8'h01 << m_owner)) != 8'h00)
        switch_now = 1'b1;
`endif
      if (switch_now) begin
        for (int k = 1; k <= 8; k++) begin
          c = (m_last + k) % 8;
          if (win < 0 && req[c] && !(m_busy && c == m_owner)) win = c;
        end
        if (win >= 0) begin
          m_owner = win;
          m_last  = win;
          m_sel   = win;
          m_busy  = 1'b1;
          m_ten   = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_ten++;
      end
    end
  end

  // Fairness bookkeeping on the DUT's own grant stream.
  int        waits[8];
  logic [7:0] prev_gnt = 8'h00;

  // Per-cycle compare against the model plus structural properties.
  always @(posedge clk) begin
    logic [7:0] exp_gnt;
    int max_wait;
    #1;
    if (m_valid) begin
      exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
      cmp("model_gnt",  32'(gnt),  32'(exp_gnt));
      cmp("model_sel",  32'(sel),  32'(m_sel));
      cmp("model_busy", 32'(busy), 32'(m_busy));
      cmp("model_y",    32'(y),    32'(m_busy & d[m_sel]));
      cmp("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (busy) cmp("sel_vs_gnt", 32'(gnt), 32'(8'h01 << sel));
      if (rst) begin
        for (int i = 0; i < 8; i++) waits[i] = 0;
      end else begin
        if (gnt != prev_gnt && gnt != 8'h00)
          for (int i = 0; i < 8; i++)
            if (req[i] && !gnt[i]) waits[i]++;
        for (int i = 0; i < 8; i++)
          if (!req[i] || gnt[i]) waits[i] = 0;
      end
      max_wait = 0;
      for (int i = 0; i < 8; i++) if (waits[i] > max_wait) max_wait = waits[i];
      cmp("wait_le_7_tenures", 32'(max_wait <= 7), 32'd1);
      prev_gnt = gnt;
    end
  end

  task automatic tick(input logic r_rst, input logic [7:0] r, input logic [7:0] dv);
    @(negedge clk);
    rst = r_rst;
    req = r;
    d   = dv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] rr;
    logic [7:0] mask;
    logic [7:0] exp8;

    // Reset state
    tick(1'b1, 8'h00, 8'h00);
    tick(1'b1, 8'h00, 8'h00);
    cmp("rst_gnt",  32'(gnt),  32'h00);
    cmp("rst_sel",  32'(sel),  32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    tick(1'b0, 8'h00, 8'h00);
    cmp("idle_busy", 32'(busy), 32'd0);

    // Single request, one-cycle latency, y follows d[0]
    tick(1'b0, 8'h01, 8'h01);
    cmp("r0_gnt",  32'(gnt),  32'h01);
    cmp("r0_sel",  32'(sel),  32'd0);
    cmp("r0_busy", 32'(busy), 32'd1);
    cmp("r0_y_hi", 32'(y),    32'd1);
    tick(1'b0, 8'h01, 8'hFE);
    cmp("r0_y_lo", 32'(y),    32'd0);
    tick(1'b0, 8'h00, 8'hFF);
    cmp("r0_rel_gnt",  32'(gnt),  32'h00);
    cmp("r0_rel_busy", 32'(busy), 32'd0);
    cmp("r0_rel_y",    32'(y),    32'd0);

    // All requesting, each owner drops for one cycle in turn
    tick(1'b1, 8'h00, 8'h00);
    tick(1'b0, 8'hFF, 8'h00);
    cmp("ff_first", 32'(gnt), 32'h01);
    for (int k = 0; k < 8; k++) begin
      mask = 8'h01 << k;
      exp8 = 8'h01 << ((k + 1) % 8);
      tick(1'b0, 8'hFF & ~mask, 8'h00);
      cmp("ff_step_gnt",  32'(gnt),  32'(exp8));
      cmp("ff_step_busy", 32'(busy), 32'd1);
      tick(1'b0, 8'hFF, 8'h00);
      cmp("ff_hold_gnt", 32'(gnt), 32'(exp8));
    end

    // Owner 3 holds while 7 waits
    tick(1'b1, 8'h00, 8'h00);
    tick(1'b0, 8'h08, 8'h00);
    cmp("hold_first", 32'(gnt), 32'h08);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 8'h88, 8'h00);
      cmp("hold_timeout", 32'(gnt), (i < 4) ? 32'h08 : 32'h80);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 8'h88, 8'h00);
      cmp("hold_forever", 32'(gnt), 32'h08);
    end
`endif

    // Owner 5 releases, requester 0 wins by wrap, then idle
    tick(1'b1, 8'h00, 8'h00);
    tick(1'b0, 8'h20, 8'h00);
    cmp("wrap_own5_gnt", 32'(gnt), 32'h20);
    cmp("wrap_own5_sel", 32'(sel), 32'd5);
    tick(1'b0, 8'h21, 8'h00);
    cmp("wrap_hold", 32'(gnt), 32'h20);
    tick(1'b0, 8'h01, 8'h00);
    cmp("wrap_gnt",  32'(gnt),  32'h01);
    cmp("wrap_sel",  32'(sel),  32'd0);
    cmp("wrap_busy", 32'(busy), 32'd1);
    tick(1'b0, 8'h00, 8'h00);
    cmp("wrap_idle_gnt",  32'(gnt),  32'h00);
    cmp("wrap_idle_busy", 32'(busy), 32'd0);
    cmp("wrap_idle_sel",  32'(sel),  32'd0);

    // Reset mid-grant overrides requests
    tick(1'b1, 8'h00, 8'h00);
    tick(1'b0, 8'h40, 8'h00);
    cmp("mid_own6", 32'(gnt), 32'h40);
    tick(1'b0, 8'hFF, 8'h00);
    cmp("mid_hold6", 32'(gnt), 32'h40);
    tick(1'b1, 8'hFF, 8'h00);
    cmp("mid_rst_gnt",  32'(gnt),  32'h00);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    tick(1'b0, 8'hFF, 8'h00);
    cmp("mid_after_gnt", 32'(gnt), 32'h01);

    // Random traffic with sticky requests
    tick(1'b1, 8'h00, 8'h00);
    rr = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      rr = rr ^ (8'($urandom) & 8'($urandom));
      tick(1'b0, rr, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
